conv_window_mul: RTL and testbench

Sequential producer for the convolution MAC stage. It loads one filter of FILTER_SIZE² weights and one IFMAP_SIZE² input feature map over valid/ready streams into local storage. It then forms every stride-1, unpadded window product and assembles the full OFMAP_SIZE² × FILTER_SIZE² product matrix. The matrix is held stable under a valid/ack handshake so the downstream row-sum MAC can reduce it to the output feature map.

---
 rtl/yolo_params_pkg.sv | 30 +++
 rtl/conv_window_row.sv | 27 ++
 rtl/conv_window_mul.sv | 136 +++++++++++++
 tb/tb_conv_window_mul.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/yolo_params_pkg.sv
// Shared sizing and types for the convolution window product stage.
package yolo_params_pkg;

  localparam int IP_DATA_WIDTH = 8;
  localparam int FILTER_SIZE   = 3;
  localparam int OFMAP_SIZE    = 4;
  localparam int IFMAP_SIZE    = OFMAP_SIZE + FILTER_SIZE - 1;

  localparam int KK         = FILTER_SIZE * FILTER_SIZE;  // weights / products per row
  localparam int II         = IFMAP_SIZE * IFMAP_SIZE;    // pixels per frame
  localparam int OO         = OFMAP_SIZE * OFMAP_SIZE;    // matrix rows
  localparam int PROD_WIDTH = 2 * IP_DATA_WIDTH;

  localparam int W_CNT_W   = $clog2(KK + 1);
  localparam int PIX_CNT_W = $clog2(II + 1);
  localparam int OUT_CNT_W = $clog2(OO);
  localparam int POS_W     = $clog2(OFMAP_SIZE);

  typedef logic [IP_DATA_WIDTH-1:0] data_t;
  typedef logic [PROD_WIDTH-1:0]    prod_t;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD_W   = 3'd1,
    S_LOAD_PIX = 3'd2,
    S_COMPUTE  = 3'd3,
    S_HOLD     = 3'd4
  } conv_win_state_t;

endpackage

// File: rtl/conv_window_row.sv
// Combinational products of one stride-1 window: element k = w[k] * pixel
// under filter tap (kr, kc) for output position (orow, ocol).
module conv_window_row
  import yolo_params_pkg::*;
(
  input  data_t [II-1:0]    pix,
  input  data_t [KK-1:0]    wts,
  input  logic  [POS_W-1:0] orow,
  input  logic  [POS_W-1:0] ocol,
  output prod_t [KK-1:0]    prods
);

  logic [PIX_CNT_W-1:0] pidx;

  // Walk the K x K taps, fetch the covered pixel and multiply at full width.
  always_comb begin
    prods = '0;
    pidx  = '0;
    for (int kr = 0; kr < FILTER_SIZE; kr++) begin
      for (int kc = 0; kc < FILTER_SIZE; kc++) begin
        pidx = PIX_CNT_W'((int'(orow) + kr) * IFMAP_SIZE + int'(ocol) + kc);
        prods[kr*FILTER_SIZE+kc] = prod_t'(wts[kr*FILTER_SIZE+kc]) * prod_t'(pix[pidx]);
      end
    end
  end

endmodule

// File: rtl/conv_window_mul.sv
// Loads a filter and an input map, then builds the OFMAP^2 x FILTER^2
// window product matrix one row per cycle and holds it for the MAC stage.
//
// Handshakes: a beat transfers on the rising edge where valid && ready are
// both high; ready depends only on the state register, never on valid.
// Output side: mat_valid stays high and matrix stays stable until mat_ack
// is seen high on an edge while in HOLD.
module conv_window_mul
  import yolo_params_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            w_valid,
  input  logic [IP_DATA_WIDTH-1:0]        w_data,
  output logic                            w_ready,
  input  logic                            pix_valid,
  input  logic [IP_DATA_WIDTH-1:0]        pix_data,
  output logic                            pix_ready,
  output logic [OO-1:0][KK-1:0][PROD_WIDTH-1:0] matrix,
  output logic                            mat_valid,
  input  logic                            mat_ack,
  output logic                            busy,
  output conv_win_state_t                 state_dbg
);

  conv_win_state_t state, state_nxt;

  logic [W_CNT_W-1:0]   w_cnt;
  logic [PIX_CNT_W-1:0] pix_cnt;
  logic [OUT_CNT_W-1:0] out_cnt;
  logic [POS_W-1:0]     orow, ocol;

  data_t [KK-1:0] wts;
  data_t [II-1:0] pix;
  prod_t [KK-1:0] row_prods;

  logic w_acc, pix_acc, w_last, pix_last, out_last;

  assign w_acc    = w_valid && w_ready;
  assign pix_acc  = pix_valid && pix_ready;
  assign w_last   = (w_cnt == W_CNT_W'(KK - 1));
  assign pix_last = (pix_cnt == PIX_CNT_W'(II - 1));
  assign out_last = (out_cnt == OUT_CNT_W'(OO - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode; start and mat_ack only matter in IDLE and HOLD.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (start)              state_nxt = S_LOAD_W;
      S_LOAD_W:   if (w_acc && w_last)    state_nxt = S_LOAD_PIX;
      S_LOAD_PIX: if (pix_acc && pix_last) state_nxt = S_COMPUTE;
      S_COMPUTE:  if (out_last)           state_nxt = S_HOLD;
      S_HOLD:     if (mat_ack)            state_nxt = S_IDLE;
      default:                            state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded straight from the state register.
  always_comb begin
    w_ready   = (state == S_LOAD_W);
    pix_ready = (state == S_LOAD_PIX);
    mat_valid = (state == S_HOLD);
    busy      = (state != S_IDLE);
    state_dbg = state;
  end

  // Beat and row counters, each cleared as its state is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_cnt   <= '0;
      pix_cnt <= '0;
      out_cnt <= '0;
      orow    <= '0;
      ocol    <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) w_cnt <= '0;
        S_LOAD_W: if (w_acc) begin
          w_cnt <= w_cnt + 1'b1;
          if (w_last) pix_cnt <= '0;
        end
        S_LOAD_PIX: if (pix_acc) begin
          pix_cnt <= pix_cnt + 1'b1;
          if (pix_last) begin
            out_cnt <= '0;
            orow    <= '0;
            ocol    <= '0;
          end
        end
        S_COMPUTE: begin
          out_cnt <= out_cnt + 1'b1;
          if (ocol == POS_W'(OFMAP_SIZE - 1)) begin
            ocol <= '0;
            orow <= orow + 1'b1;
          end else begin
            ocol <= ocol + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Weight and pixel storage, written at the running beat index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wts <= '0;
      pix <= '0;
    end else begin
      if (w_acc)   wts[w_cnt]   <= w_data;
      if (pix_acc) pix[pix_cnt] <= pix_data;
    end
  end

  conv_window_row u_row (
    .pix   (pix),
    .wts   (wts),
    .orow  (orow),
    .ocol  (ocol),
    .prods (row_prods)
  );

  // Capture one matrix row per COMPUTE cycle; rows persist until rewritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  matrix <= '0;
    else if (state == S_COMPUTE) matrix[out_cnt] <= row_prods;
  end

endmodule

// File: tb/tb_conv_window_mul.sv
// Directed bench for conv_window_mul: streams a filter and a map, checks
// latency, matrix rows, handshake side effects and mid-frame reset.
module tb_conv_window_mul;
  import yolo_params_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic w_valid = 1'b0;
  logic [IP_DATA_WIDTH-1:0] w_data = '0;
  logic w_ready;
  logic pix_valid = 1'b0;
  logic [IP_DATA_WIDTH-1:0] pix_data = '0;
  logic pix_ready;
  logic [OO-1:0][KK-1:0][PROD_WIDTH-1:0] matrix;
  logic mat_valid;
  logic mat_ack = 1'b0;
  logic busy;
  conv_win_state_t state_dbg;

  int n_cmp = 0;
  int n_bad = 0;

  logic [IP_DATA_WIDTH-1:0] wts [KK];
  logic [IP_DATA_WIDTH-1:0] pixv [II];

  conv_window_mul dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .w_valid   (w_valid),
    .w_data    (w_data),
    .w_ready   (w_ready),
    .pix_valid (pix_valid),
    .pix_data  (pix_data),
    .pix_ready (pix_ready),
    .matrix    (matrix),
    .mat_valid (mat_valid),
    .mat_ack   (mat_ack),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [KK*PROD_WIDTH-1:0] pack_row(input int e [KK]);
    logic [KK*PROD_WIDTH-1:0] r;
    r = '0;
    for (int k = 0; k < KK; k++) r[k*PROD_WIDTH +: PROD_WIDTH] = PROD_WIDTH'(e[k]);
    return r;
  endfunction

  // reference row from the window formula over the bench's own arrays
  function automatic logic [KK*PROD_WIDTH-1:0] model_row(input int r);
    int e [KK];
    int orw, ocl;
    orw = r / OFMAP_SIZE;
    ocl = r % OFMAP_SIZE;
    for (int kr = 0; kr < FILTER_SIZE; kr++)
      for (int kc = 0; kc < FILTER_SIZE; kc++)
        e[kr*FILTER_SIZE+kc] = int'(wts[kr*FILTER_SIZE+kc]) *
                               int'(pixv[(orw+kr)*IFMAP_SIZE + ocl + kc]);
    return pack_row(e);
  endfunction

  // driver: starts a frame at the current negedge (cycle 0) and streams data.
  // Returns the cycle mat_valid is first seen, -1 on timeout, -2 on abort.
  task automatic run_frame(input bit toggle, input bit disturb, input int abort_pix,
                           output int latency);
    int wi, pi, n;
    bit phase, done;
    wi = 0; pi = 0; n = 0; phase = 1'b0; done = 1'b0; latency = -1;
    @(negedge clk);
    while (!done && n < 400) begin
      start     = (n == 0) || (disturb && (n == 20 || n == 50));
      mat_ack   = disturb && (n == 50);
      w_valid   = (wi < KK);
      w_data    = w_valid ? wts[wi] : '0;
      pix_valid = (pi < II) && (!toggle || phase);
      pix_data  = pix_valid ? pixv[pi] : '0;
      if (w_valid && w_ready) wi++;
      if (pix_valid && pix_ready) pi++;
      if (pix_ready) phase = ~phase;
      if (mat_valid) begin
        latency = n;
        done = 1'b1;
      end else if (abort_pix >= 0 && pi == abort_pix) begin
        latency = -2;
        done = 1'b1;
      end else begin
        @(negedge clk);
        n++;
      end
    end
    start = 1'b0; mat_ack = 1'b0;
    if (latency != -2) begin
      w_valid = 1'b0; pix_valid = 1'b0;
    end
    if (latency == -1) $display("FAIL frame_timeout: got no mat_valid expected mat_valid within 400 cycles");
  endtask

  task automatic check_all_rows(input string tag);
    for (int r = 0; r < OO; r++)
      check($sformatf("%s_row%0d", tag, r), 160'(matrix[r]), 160'(model_row(r)));
  endtask

  // ack at the current (HOLD) cycle and verify release on the next cycle
  task automatic ack_and_check(input string tag);
    mat_ack = 1'b1;
    @(negedge clk);
    mat_ack = 1'b0;
    check({tag, "_valid_after_ack"}, 160'(mat_valid), 160'(0));
    check({tag, "_busy_after_ack"}, 160'(busy), 160'(0));
  endtask

  int lat;
  int e0 [KK];
  int e15 [KK];
  int ew [KK];
  int e255 [KK];
  logic [KK*PROD_WIDTH-1:0] row_snap;

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    check("rst_w_ready", 160'(w_ready), 160'(0));
    check("rst_pix_ready", 160'(pix_ready), 160'(0));
    check("rst_mat_valid", 160'(mat_valid), 160'(0));
    check("rst_busy", 160'(busy), 160'(0));
    check("rst_matrix_zero", 160'(|matrix), 160'(0));
    check("rst_state", 160'(state_dbg), 160'(S_IDLE));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // T1: weights 1, pixel = index
    for (int k = 0; k < KK; k++) wts[k] = 8'd1;
    for (int p = 0; p < II; p++) pixv[p] = 8'(p);
    e0  = '{0, 1, 2, 6, 7, 8, 12, 13, 14};
    e15 = '{21, 22, 23, 27, 28, 29, 33, 34, 35};
    run_frame(1'b0, 1'b0, -1, lat);
    check("t1_latency", 160'(lat), 160'(62));
    check("t1_row0_hand", 160'(matrix[0]), 160'(pack_row(e0)));
    check("t1_row15_hand", 160'(matrix[15]), 160'(pack_row(e15)));
    check_all_rows("t1");
    row_snap = matrix[5];
    repeat (3) @(negedge clk);
    check("t1_hold_valid", 160'(mat_valid), 160'(1));
    check("t1_hold_stable", 160'(matrix[5]), 160'(row_snap));
    ack_and_check("t1");
    check("t1_matrix_retained", 160'(matrix[15]), 160'(pack_row(e15)));

    // T2: all 255, full 16-bit products; start together with ack is not latched
    for (int k = 0; k < KK; k++) begin wts[k] = 8'hFF; e255[k] = 65025; end
    for (int p = 0; p < II; p++) pixv[p] = 8'hFF;
    run_frame(1'b0, 1'b0, -1, lat);
    check("t2_latency", 160'(lat), 160'(62));
    for (int r = 0; r < OO; r++)
      check($sformatf("t2_row%0d", r), 160'(matrix[r]), 160'(pack_row(e255)));
    start = 1'b1;
    ack_and_check("t2");
    start = 1'b0;
    @(negedge clk);
    check("t2_start_not_latched", 160'(busy), 160'(0));

    // T3: pix_valid toggling, starting low
    for (int k = 0; k < KK; k++) wts[k] = 8'd1;
    for (int p = 0; p < II; p++) pixv[p] = 8'(p);
    run_frame(1'b1, 1'b0, -1, lat);
    check("t3_latency", 160'(lat), 160'(98));
    check("t3_row0_hand", 160'(matrix[0]), 160'(pack_row(e0)));
    check_all_rows("t3");
    ack_and_check("t3");

    // T4: stray start in LOAD_PIX/COMPUTE, stray mat_ack in COMPUTE
    run_frame(1'b0, 1'b1, -1, lat);
    check("t4_latency", 160'(lat), 160'(62));
    check_all_rows("t4");
    ack_and_check("t4");

    // T5: reset after 10 pixels accepted, then a clean frame
    run_frame(1'b0, 1'b0, 10, lat);
    @(negedge clk);
    w_valid = 1'b0; pix_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t5_rst_state", 160'(state_dbg), 160'(S_IDLE));
    check("t5_rst_outputs", 160'({w_ready, pix_ready, mat_valid, busy}), 160'(0));
    check("t5_rst_matrix", 160'(|matrix), 160'(0));
    repeat (2) @(negedge clk);
    check("t5_rst_held_state", 160'(state_dbg), 160'(S_IDLE));
    check("t5_rst_held_valid", 160'(mat_valid), 160'(0));
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(1'b0, 1'b0, -1, lat);
    check("t5_latency", 160'(lat), 160'(62));
    check("t5_row15_hand", 160'(matrix[15]), 160'(pack_row(e15)));
    check_all_rows("t5");
    ack_and_check("t5");

    // T6: weights 1..9, pixels 2
    for (int k = 0; k < KK; k++) begin wts[k] = 8'(k + 1); ew[k] = 2 * (k + 1); end
    for (int p = 0; p < II; p++) pixv[p] = 8'd2;
    run_frame(1'b0, 1'b0, -1, lat);
    check("t6_latency", 160'(lat), 160'(62));
    for (int r = 0; r < OO; r++)
      check($sformatf("t6_row%0d", r), 160'(matrix[r]), 160'(pack_row(ew)));
    ack_and_check("t6");

    // report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
